// File: rtl/mmio_uart_tx_if.sv
// Memory-mapped bus between the core's data-memory port and the UART transmitter.
interface mmio_uart_tx_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        sel;

   modport master (output addr, we, wd, input rd, sel);
   modport slave  (input addr, we, wd, output rd, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS registers, TX queue and 8N1 serialiser.
// Define UART_TX_FIFO_EN for a 4-entry queue; otherwise a single holding register.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          CLKS_PER_BIT = 868
) (
   input  logic            clk,
   input  logic            rst_n,
   mmio_uart_tx_if.slave   bus,
   output logic            tx
);

   localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n;
   logic             tx_n;
   logic             pop, push, full, empty, ovf;
   logic [7:0]       head;
   logic [1:0]       offset;
   logic             wr_txdata, wr_status, busy, bit_last;
   logic             unused_bits;

   assign offset      = bus.addr[3:2];
   assign bus.sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign wr_txdata   = bus.sel && bus.we && (offset == 2'd0);
   assign wr_status   = bus.sel && bus.we && (offset == 2'd1);
   assign push        = wr_txdata && !full;
   assign busy        = (state != IDLE);
   assign bit_last    = (bit_cnt == CNT_LAST);
   assign unused_bits = ^{bus.addr[1:0], bus.wd[31:8]};

   always_comb begin
      bus.rd = 32'd0;
      if (bus.sel && offset == 2'd1)
         bus.rd = {28'd0, ovf, empty, full, busy};
   end

`ifdef UART_TX_FIFO_EN
   logic [7:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;

   assign full  = (count == 3'd4);
   assign empty = (count == 3'd0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wd[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end
`else
   logic [7:0] hold;
   logic       occ;

   assign full  = occ;
   assign empty = !occ;
   assign head  = hold;

   // The holding register can never be pushed and popped on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= 8'd0;
         occ  <= 1'b0;
      end else if (push) begin
         hold <= bus.wd[7:0];
         occ  <= 1'b1;
      end else if (pop) begin
         occ  <= 1'b0;
      end
   end
`endif

   // A dropped write re-arms overflow even if software clears it on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         ovf <= 1'b0;
      else if (wr_txdata && full)         ovf <= 1'b1;
      else if (wr_status && bus.wd[3])    ovf <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         tx      <= tx_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      tx_n      = tx;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shreg_n   = head;
               bit_cnt_n = '0;
               state_n   = START;
               tx_n      = 1'b0;
            end
         end
         START: begin
            if (bit_last) begin
               bit_cnt_n = '0;
               state_n   = DATA;
               tx_n      = shreg[0];
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_last) begin
               bit_cnt_n = '0;
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  shreg_n = {1'b0, shreg[7:1]};
                  tx_n    = shreg[1];
               end
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_last) begin
               bit_cnt_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = head;
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes, a line monitor decodes frames.
module tb_mmio_uart_tx;
   localparam int          CPB  = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx;

   mmio_uart_tx_if bus();

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [7:0]  exp_q[$];
   int          starts[$];
   bit          in_frame = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr = a;
      bus.wd   = d;
      bus.we   = 1'b1;
      @(posedge clk);
      #1;
      bus.we   = 1'b0;
   endtask

   task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      bus.addr = a;
      bus.we   = 1'b0;
      #1;
      chk(name, bus.rd, exp);
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !in_frame) begin
            done = 1'b1;
            break;
         end
      end
      chk({name, "_drain"}, {31'd0, done}, 32'd1);
   endtask

   // Line monitor: samples every cycle of a frame at the falling edge.
   initial begin : monitor
      logic       s [40];
      logic [7:0] b;
      bit         ok;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            in_frame = 1'b1;
            aborted  = 1'b0;
            starts.push_back(cyc);
            s[0] = tx;
            for (int k = 1; k < 40; k++) begin
               @(negedge clk);
               if (!rst_n) aborted = 1'b1;
               s[k] = tx;
            end
            if (!aborted) begin
               ok = 1'b1;
               for (int j = 0; j < 4; j++) begin
                  if (s[j] !== 1'b0)      ok = 1'b0;
                  if (s[36 + j] !== 1'b1) ok = 1'b0;
               end
               for (int i = 0; i < 8; i++) begin
                  b[i] = s[4 + 4*i];
                  for (int j = 1; j < 4; j++)
                     if (s[4 + 4*i + j] !== b[i]) ok = 1'b0;
               end
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame_unexpected: got %02h expected no frame", b);
               end else begin
                  chk("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
               end
               chk("frame_shape", {31'd0, ok}, 32'd1);
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : stim
      int lows;
      bus.addr = 32'd0;
      bus.we   = 1'b0;
      bus.wd   = 32'd0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset state and decode
      rdchk("status_reset", BASE + 32'h4, 32'h4);
      chk("sel_in", {31'd0, bus.sel}, 32'd1);
      chk("tx_reset", {31'd0, tx}, 32'd1);
      rdchk("rd_outside", 32'h0000_0004, 32'h0);
      chk("sel_outside", {31'd0, bus.sel}, 32'd0);
      rdchk("status_alias", BASE + 32'h7, 32'h4);
      rdchk("txdata_read", BASE, 32'h0);
      rdchk("offset8_read", BASE + 32'h8, 32'h0);

      // Writes that must not queue anything
      wr(BASE + 32'hC, 32'h77);
      wr(BASE + 32'h4, 32'h01);
      wr(32'h2000_0000, 32'h66);
      repeat (3) @(posedge clk);
      rdchk("status_no_push", BASE + 32'h4, 32'h4);

      // Single frame 0x55 with exact edge timing
      exp_q.push_back(8'h55);
      wr(BASE, 32'h55);
      chk("tx_before_start", {31'd0, tx}, 32'd1);
      bus.addr = BASE + 32'h4;
      @(posedge clk); #1;
      chk("tx_start_edge", {31'd0, tx}, 32'd0);
      chk("status_busy", bus.rd, 32'h5);
      repeat (39) @(posedge clk); #1;
      chk("busy_last_stop", bus.rd, 32'h5);
      @(posedge clk); #1;
      chk("busy_cleared", bus.rd, 32'h4);
      wait_idle("single", 100);

      // Two frames back to back
      starts.delete();
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'h3C);
`ifdef UART_TX_FIFO_EN
      wr(BASE, 32'hA1);
      wr(BASE, 32'h3C);
`else
      wr(BASE, 32'hA1);
      @(posedge clk);
      wr(BASE, 32'h3C);
`endif
      wait_idle("b2b", 200);
      chk("b2b_frames", starts.size(), 32'd2);
      if (starts.size() == 2)
         chk("b2b_gap", starts[1] - starts[0], 32'd40);

      // Overflow and clear
      starts.delete();
`ifdef UART_TX_FIFO_EN
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
      for (int i = 0; i < 6; i++) wr(BASE, 32'h11 + i);
      rdchk("status_overflow", BASE + 32'h4, 32'hB);
      wr(BASE + 32'h4, 32'h8);
      rdchk("status_ovf_clear", BASE + 32'h4, 32'h3);
      wait_idle("fifo", 400);
      chk("fifo_frames", starts.size(), 32'd5);
`else
      exp_q.push_back(8'hB1);
      exp_q.push_back(8'hB2);
      wr(BASE, 32'hB1);
      @(posedge clk);
      wr(BASE, 32'hB2);
      wr(BASE, 32'hB3);
      rdchk("status_overflow", BASE + 32'h4, 32'hB);
      wr(BASE + 32'h4, 32'h8);
      rdchk("status_ovf_clear", BASE + 32'h4, 32'h3);
      wait_idle("hold", 200);
      chk("hold_frames", starts.size(), 32'd2);
`endif
      rdchk("status_idle", BASE + 32'h4, 32'h4);

      // Asynchronous reset in the middle of a frame
      wr(BASE, 32'h5A);
      bus.addr = BASE + 32'h4;
      @(posedge clk);
      repeat (16) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("tx_async_reset", {31'd0, tx}, 32'd1);
      chk("status_async_reset", bus.rd, 32'h4);
      #4 rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("no_resume", lows, 32'd0);
      rdchk("status_after_reset", BASE + 32'h4, 32'h4);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
